// File: rtl/stream_burst_write_master.sv
// Stream sink: buffers valid-strobed samples and writes them to memory as Avalon-MM bursts.
// First avm_write rises 2 cycles after the sample completing a burst; the stream has no backpressure, so samples are dropped when the FIFO is full and overflow is flagged.
module stream_burst_write_master #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int                LENGTH     = 1024,
    parameter int                BURST_LEN  = 8,
    parameter int                FIFO_DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            d_in,
    input  logic                         v,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [ADDR_W-1:0]            avm_address,
    output logic                         avm_write,
    output logic [DATA_W-1:0]            avm_writedata,
    output logic [DATA_W/8-1:0]          avm_byteenable,
    output logic [$clog2(BURST_LEN):0]   avm_burstcount,
    input  logic                         avm_waitrequest
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(LENGTH + 1);
    localparam int BC_W  = $clog2(BURST_LEN) + 1;
    localparam int BYTES = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ARMED, BURST, DONE} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_count;
    logic [CNT_W-1:0]  captured, remaining;
    logic [ADDR_W-1:0] addr;
    logic [BC_W-1:0]   beats_left;
    logic [BC_W-1:0]   burst_need;

    logic fifo_full, capturing, push, drop, beat_ok, last_beat, burst_ready, accept_start;

    always_comb begin
        fifo_full    = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
        accept_start = start && ((state == IDLE) || (state == DONE));
        capturing    = ((state == ARMED) || (state == BURST)) && (captured != CNT_W'(LENGTH));
        push         = capturing && v && !fifo_full;
        drop         = capturing && v && fifo_full;
        beat_ok      = avm_write && !avm_waitrequest;
        last_beat    = beat_ok && (beats_left == BC_W'(1));
        burst_need   = (int'(remaining) >= BURST_LEN) ? BC_W'(BURST_LEN) : BC_W'(remaining);
        burst_ready  = (fifo_count >= (PTR_W+1)'(burst_need));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start)       state_nxt = ARMED;
            ARMED:      if (burst_ready) state_nxt = BURST;
            BURST:      if (last_beat)   state_nxt = (remaining == CNT_W'(1)) ? DONE : ARMED;
            default:                     state_nxt = IDLE;
        endcase
    end

    assign busy           = (state == ARMED) || (state == BURST);
    assign done           = (state == DONE);
    // Head of FIFO is presented directly, so the next beat follows an accepted one with no bubble.
    assign avm_writedata  = avm_write ? mem[rd_ptr] : '0;
    assign avm_byteenable = avm_write ? '1 : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= d_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            captured       <= '0;
            remaining      <= '0;
            addr           <= '0;
            beats_left     <= '0;
            overflow       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_burstcount <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
            if (beat_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, beat_ok})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (accept_start) begin
                overflow  <= 1'b0;
                captured  <= '0;
                remaining <= CNT_W'(LENGTH);
                addr      <= BASE_ADDR;
            end else begin
                if (drop)    overflow  <= 1'b1;
                if (push)    captured  <= captured + CNT_W'(1);
                if (beat_ok) remaining <= remaining - CNT_W'(1);
            end

            if ((state == ARMED) && burst_ready) begin
                avm_write      <= 1'b1;
                avm_address    <= addr;
                avm_burstcount <= burst_need;
                beats_left     <= burst_need;
            end

            if (beat_ok) begin
                beats_left <= beats_left - BC_W'(1);
                if (last_beat) begin
                    avm_write <= 1'b0;
                    addr      <= addr + ADDR_W'(avm_burstcount) * ADDR_W'(BYTES);
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_burst_write_master.sv
// Bench for stream_burst_write_master: directed and random runs scored against a queue-based model
// of stored samples, burst sizes, addresses and first-write latency.
module tb_stream_burst_write_master;

    localparam int          DATA_W     = 16;
    localparam int          ADDR_W     = 32;
    localparam logic [31:0] BASE_ADDR  = 32'hFFFF_FFF0;
    localparam int          LENGTH     = 37;
    localparam int          BURST_LEN  = 8;
    localparam int          FIFO_DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] d_in;
    logic        v, start, avm_waitrequest;
    logic        busy, done, overflow, avm_write;
    logic [31:0] avm_address;
    logic [15:0] avm_writedata;
    logic [1:0]  avm_byteenable;
    logic [3:0]  avm_burstcount;

    initial forever #5 clk = ~clk;

    stream_burst_write_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR),
        .LENGTH(LENGTH), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .d_in(d_in), .v(v), .start(start),
        .busy(busy), .done(done), .overflow(overflow),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest)
    );

    // Model state: samples stored but not yet written, plus run/burst bookkeeping.
    logic [15:0] sq[$];
    int          captured_m, written_m, beat_m, bc_m, cyc, fill_cyc;
    bit          active_m, done_m, ovf_m, in_burst;
    logic [31:0] addr_m;
    int          n_checks, n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_clear();
        sq.delete();
        active_m = 0; done_m = 0; ovf_m = 0; in_burst = 0;
        beat_m = 0; bc_m = 0; captured_m = 0; written_m = 0; fill_cyc = -1;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_overflow"}, overflow, 0);
        check({pfx, "_address"}, avm_address, 0);
        check({pfx, "_write"}, avm_write, 0);
        check({pfx, "_writedata"}, avm_writedata, 0);
        check({pfx, "_byteenable"}, avm_byteenable, 0);
        check({pfx, "_burstcount"}, avm_burstcount, 0);
    endtask

    // One clock: check outputs at the falling edge, then drive the inputs the next rising edge consumes.
    task automatic cycle(input logic v_i, input logic [15:0] d_i, input logic st_i, input logic wr_i);
        @(negedge clk);
        cyc++;
        check("busy", busy, active_m);
        check("done", done, done_m);
        check("overflow", overflow, ovf_m);
        if (avm_write) begin
            check("write_in_run", active_m, 1);
            if (!in_burst) begin
                if (written_m == 0 && fill_cyc >= 0) check("latency", cyc - fill_cyc, 2);
                in_burst = 1;
                beat_m   = 0;
                bc_m     = min_i(BURST_LEN, LENGTH - written_m);
                addr_m   = BASE_ADDR + 32'(written_m * 2);
                check("prebuffered", sq.size() >= bc_m, 1);
            end
            check("address", avm_address, addr_m);
            check("burstcount", avm_burstcount, bc_m);
            check("byteenable", avm_byteenable, 2'b11);
            if (sq.size() > 0) check("writedata", avm_writedata, sq[0]);
        end else begin
            check("no_gap", in_burst, 0);
            check("byteenable_idle", avm_byteenable, 0);
        end

        v = v_i; d_in = d_i; start = st_i; avm_waitrequest = wr_i;

        if (active_m && captured_m < LENGTH && v_i) begin
            if (sq.size() < FIFO_DEPTH) begin
                sq.push_back(d_i);
                captured_m++;
                if (written_m == 0 && !in_burst && fill_cyc < 0 && sq.size() >= min_i(BURST_LEN, LENGTH))
                    fill_cyc = cyc;
            end else begin
                ovf_m = 1;
            end
        end
        if (st_i && !active_m) begin
            active_m = 1; done_m = 0; ovf_m = 0;
            captured_m = 0; written_m = 0; fill_cyc = -1;
        end
        if (avm_write && !wr_i && in_burst && sq.size() > 0) begin
            void'(sq.pop_front());
            written_m++;
            beat_m++;
            if (beat_m == bc_m) in_burst = 0;
            if (written_m == LENGTH) begin
                active_m = 0;
                done_m   = 1;
            end
        end
    endtask

    // mode 0: continuous stream; 1: continuous stream with a 20-cycle stall and a stray start; 2: random.
    task automatic run(input int mode, input int budget);
        int t = 0;
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        while (active_m && t < budget) begin
            case (mode)
                0:       cycle(1'b1, 16'(t + 16'h0100), 1'b0, 1'b0);
                1:       cycle(1'b1, 16'(t + 16'h0200), t == 14, (t >= 12 && t < 32));
                default: cycle($urandom_range(0, 99) < 70, 16'($urandom), $urandom_range(0, 99) < 5,
                               $urandom_range(0, 99) < 30);
            endcase
            t++;
        end
        if (active_m) check("run_timeout", done, 1);
        for (int k = 0; k < 5; k++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0; n_err = 0; cyc = 0;
        model_clear();
        v = 0; d_in = '0; start = 0; avm_waitrequest = 0; reset = 1;
        repeat (2) @(negedge clk);
        check_zero("rst");
        reset = 0;

        run(0, 500);
        run(1, 500);
        check("overflow_seen", ovf_m, 1);
        for (int r = 0; r < 6; r++) run(2, 2000);

        // Reset while the third beat of the first burst is on the bus.
        begin
            int k = 0;
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
            while (!(in_burst && beat_m == 2) && k < 100) begin
                cycle(1'b1, 16'(k + 16'h0300), 1'b0, 1'b0);
                k++;
            end
            check("reached_beat3", beat_m, 2);
            @(posedge clk);
            #2 reset = 1;
            #1 check_zero("async_rst");
            model_clear();
            @(negedge clk);
            @(negedge clk);
            check_zero("rst_hold");
            reset = 0;
        end
        run(0, 500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
